// File: rtl/pw_entry_buf.sv
// pw_entry_buf -- keypad password buffer for the doorlock datapath.
//
// Collects keypad digits into a pad-filled shift register (newest digit in the
// low nibble), tracks entry length, supports backspace and clear, commits an
// entry as the stored password, compares entries against it and locks out all
// commands for LOCK_CYCLES clocks after MAX_FAILS consecutive failed checks.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   clr          clear entry buffer
//   digit_valid  push digit_in
//   digit_in     digit value (DIGIT_W bits)
//   backspace    remove most recent digit
//   set_pw       commit entry as stored password (needs >= MIN_LEN digits)
//   check        compare entry with stored password
//   entry_data   entry register, newest digit in [DIGIT_W-1:0], unused slots all-ones
//   entry_len    digits currently held
//   full/empty   entry_len == MAX_DIGITS / entry_len == 0
//   pw_set       a stored password exists
//   match/fail   1-cycle result pulses of a check
//   set_err      1-cycle pulse: set_pw rejected, entry too short
//   locked       lockout active, every command ignored
// Command priority (one per cycle): clr > check > set_pw > backspace > digit_valid.

module pw_entry_buf #(
    parameter int DIGIT_W     = 4,
    parameter int MAX_DIGITS  = 32,
    parameter int MIN_LEN     = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              digit_valid,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              backspace,
    input  logic                              set_pw,
    input  logic                              check,
    output logic [DIGIT_W*MAX_DIGITS-1:0]     entry_data,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   entry_len,
    output logic                              full,
    output logic                              empty,
    output logic                              pw_set,
    output logic                              match,
    output logic                              fail,
    output logic                              set_err,
    output logic                              locked
);

    localparam int LW = $clog2(MAX_DIGITS + 1);
    localparam int DW = DIGIT_W * MAX_DIGITS;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int CW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] stored;
    logic [LW-1:0] stored_len;
    logic [FW-1:0] fail_cnt;
    logic [CW-1:0] lock_cnt;

    logic is_locked;
    logic do_clr, do_check, do_set, do_bs, do_push;
    logic set_ok, entry_eq, trip;

    assign full   = (entry_len == LW'(MAX_DIGITS));
    assign empty  = (entry_len == '0);
    assign locked = is_locked;

    always_comb begin
        is_locked = (state == LOCKED);
        do_clr    = !is_locked && clr;
        do_check  = !is_locked && !clr && check;
        do_set    = !is_locked && !clr && !check && set_pw;
        do_bs     = !is_locked && !clr && !check && !set_pw && backspace;
        do_push   = !is_locked && !clr && !check && !set_pw && !backspace && digit_valid;
        set_ok    = (entry_len >= LW'(MIN_LEN));
        // Unused slots hold the pad value, so a full-vector compare plus the
        // length compare is exact even for digits equal to the pad.
        entry_eq  = pw_set && (entry_len == stored_len) && (entry_data == stored);
        trip      = do_check && !entry_eq && (fail_cnt == FW'(MAX_FAILS - 1));

        state_nxt = state;
        case (state)
            LOCKED: begin
                if (lock_cnt == '0) state_nxt = IDLE;
            end
            default: begin
                if (do_clr)                 state_nxt = IDLE;
                else if (do_check)          state_nxt = trip ? LOCKED : IDLE;
                else if (do_set && set_ok)  state_nxt = IDLE;
                else if (do_bs && !empty)   state_nxt = (entry_len == LW'(1)) ? IDLE : ENTRY;
                else if (do_push && !full)  state_nxt = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_data <= '1;
            entry_len  <= '0;
            stored     <= '1;
            stored_len <= '0;
            pw_set     <= 1'b0;
            fail_cnt   <= '0;
            lock_cnt   <= '0;
            match      <= 1'b0;
            fail       <= 1'b0;
            set_err    <= 1'b0;
        end else begin
            match   <= 1'b0;
            fail    <= 1'b0;
            set_err <= 1'b0;
            if (is_locked) begin
                if (lock_cnt == '0) fail_cnt <= '0;
                else                lock_cnt <= lock_cnt - 1'b1;
            end else if (do_clr) begin
                entry_data <= '1;
                entry_len  <= '0;
            end else if (do_check) begin
                entry_data <= '1;
                entry_len  <= '0;
                if (entry_eq) begin
                    match    <= 1'b1;
                    fail_cnt <= '0;
                end else begin
                    fail <= 1'b1;
                    if (fail_cnt != FW'(MAX_FAILS)) fail_cnt <= fail_cnt + 1'b1;
                    if (trip) lock_cnt <= CW'(LOCK_CYCLES - 1);
                end
            end else if (do_set) begin
                if (set_ok) begin
                    stored     <= entry_data;
                    stored_len <= entry_len;
                    pw_set     <= 1'b1;
                    fail_cnt   <= '0;
                    entry_data <= '1;
                    entry_len  <= '0;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (do_bs) begin
                if (!empty) begin
                    entry_data <= {{DIGIT_W{1'b1}}, entry_data[DW-1:DIGIT_W]};
                    entry_len  <= entry_len - 1'b1;
                end
            end else if (do_push) begin
                if (!full) begin
                    entry_data <= {entry_data[DW-DIGIT_W-1:0], digit_in};
                    entry_len  <= entry_len + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pw_entry_buf.sv
// Testbench for pw_entry_buf: directed scenarios plus randomized command
// streams, checked against a queue-based reference model of the entry buffer,
// stored password, fail count and lockout window.
module tb_pw_entry_buf;

    localparam int DIGIT_W     = 4;
    localparam int MAX_DIGITS  = 32;
    localparam int MIN_LEN     = 4;
    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 1000;
    localparam int LW = $clog2(MAX_DIGITS + 1);
    localparam int DW = DIGIT_W * MAX_DIGITS;

    logic clk = 1'b0;
    logic rst, clr, digit_valid, backspace, set_pw, check;
    logic [DIGIT_W-1:0] digit_in;
    logic [DW-1:0] entry_data;
    logic [LW-1:0] entry_len;
    logic full, empty, pw_set, match, fail, set_err, locked;

    always #5 clk = ~clk;

    pw_entry_buf #(
        .DIGIT_W(DIGIT_W), .MAX_DIGITS(MAX_DIGITS), .MIN_LEN(MIN_LEN),
        .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .digit_valid(digit_valid),
        .digit_in(digit_in), .backspace(backspace), .set_pw(set_pw), .check(check),
        .entry_data(entry_data), .entry_len(entry_len), .full(full), .empty(empty),
        .pw_set(pw_set), .match(match), .fail(fail), .set_err(set_err), .locked(locked)
    );

    typedef struct {
        int          len;
        logic [DW-1:0] data;
        bit          lck;
        bit          pws;
    } snap_t;

    snap_t      snap_q[$];
    logic [2:0] pulse_q[$];   // {match, fail, set_err}

    // reference model
    int unsigned ent[$];
    int unsigned sto[$];
    bit      m_pwset;
    int      m_fails;
    longint  cyc;
    bit      lock_valid;
    longint  lock_edge;
    bit      done;

    int errors = 0;
    int checks = 0;

    function automatic bit is_lock(longint k);
        return lock_valid && (k >= lock_edge) && ((k - lock_edge) < LOCK_CYCLES);
    endfunction

    function automatic bit same_pw();
        if (!m_pwset || ent.size() != sto.size()) return 0;
        for (int i = 0; i < ent.size(); i++)
            if (ent[i] != sto[i]) return 0;
        return 1;
    endfunction

    function automatic void push_snap();
        snap_t s;
        s.len  = ent.size();
        s.data = '1;
        for (int i = 0; i < ent.size(); i++)
            s.data[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(ent[ent.size()-1-i]);
        s.lck = is_lock(cyc);
        s.pws = m_pwset;
        snap_q.push_back(s);
    endfunction

    function automatic void model_reset();
        ent.delete();
        sto.delete();
        m_pwset    = 0;
        m_fails    = 0;
        lock_valid = 0;
        pulse_q.delete();
    endfunction

    function automatic void model_apply(bit c, bit chk, bit sp, bit bs, bit dv, int unsigned d);
        cyc++;
        if (is_lock(cyc - 1)) begin
            if (!is_lock(cyc)) m_fails = 0;
        end else if (c) begin
            ent.delete();
        end else if (chk) begin
            if (same_pw()) begin
                pulse_q.push_back(3'b100);
                m_fails = 0;
            end else begin
                pulse_q.push_back(3'b010);
                if (m_fails < MAX_FAILS) m_fails++;
                if (m_fails == MAX_FAILS) begin
                    lock_valid = 1;
                    lock_edge  = cyc;
                end
            end
            ent.delete();
        end else if (sp) begin
            if (ent.size() >= MIN_LEN) begin
                sto     = ent;
                m_pwset = 1;
                m_fails = 0;
                ent.delete();
            end else begin
                pulse_q.push_back(3'b001);
            end
        end else if (bs) begin
            if (ent.size() > 0) void'(ent.pop_back());
        end else if (dv) begin
            if (ent.size() < MAX_DIGITS) ent.push_back(d);
        end
        push_snap();
    endfunction

    task automatic step(input bit c, input bit chk, input bit sp, input bit bs,
                        input bit dv, input int unsigned d);
        clr = c; check = chk; set_pw = sp; backspace = bs; digit_valid = dv;
        digit_in = DIGIT_W'(d);
        @(posedge clk);
        model_apply(c, chk, sp, bs, dv, d);
        #1;
        clr = 0; check = 0; set_pw = 0; backspace = 0; digit_valid = 0; digit_in = '0;
    endtask

    task automatic push_d(input int unsigned d);  step(0, 0, 0, 0, 1, d); endtask
    task automatic do_check();                    step(0, 1, 0, 0, 0, 0); endtask
    task automatic do_set();                      step(0, 0, 1, 0, 0, 0); endtask
    task automatic do_bs();                       step(0, 0, 0, 1, 0, 0); endtask
    task automatic do_clr();                      step(1, 0, 0, 0, 0, 0); endtask
    task automatic idle();                        step(0, 0, 0, 0, 0, 0); endtask

    task automatic push_1234();
        for (int i = 1; i <= 4; i++) push_d(i);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1;
        model_reset();
        push_snap();
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    // monitor / scoreboard
    initial begin
        snap_t s;
        logic [2:0] p;
        while (!done) begin
            @(negedge clk);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                checks++;
                if (entry_len !== LW'(s.len) || entry_data !== s.data || locked !== s.lck ||
                    pw_set !== s.pws || full !== (s.len == MAX_DIGITS) || empty !== (s.len == 0)) begin
                    errors++;
                    $display("FAIL state t=%0t got len=%0d data=%h locked=%b pw_set=%b full=%b empty=%b expected len=%0d data=%h locked=%b pw_set=%b",
                             $time, entry_len, entry_data, locked, pw_set, full, empty,
                             s.len, s.data, s.lck, s.pws);
                end
            end
            if (match !== 1'b0 || fail !== 1'b0 || set_err !== 1'b0) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse t=%0t got {match,fail,set_err}=%b expected no pulse",
                             $time, {match, fail, set_err});
                end else begin
                    p = pulse_q.pop_front();
                    if ({match, fail, set_err} !== p) begin
                        errors++;
                        $display("FAIL pulse t=%0t got {match,fail,set_err}=%b expected %b",
                                 $time, {match, fail, set_err}, p);
                    end
                end
            end
        end
        checks++;
        if (pulse_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulse got %0d pulses never seen expected 0", pulse_q.size());
        end
        checks++;
        if (snap_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_state got %0d unchecked expected 0", snap_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int unsigned r;
        done = 0;
        cyc  = 0;
        rst  = 1;
        clr = 0; check = 0; set_pw = 0; backspace = 0; digit_valid = 0; digit_in = '0;
        model_reset();
        push_snap();
        repeat (2) @(negedge clk);
        #1;
        rst = 0;

        push_1234(); do_set();                          // commit 1234
        push_1234(); do_check();                        // match
        for (int i = 1; i <= 3; i++) push_d(i);
        do_check();                                     // fail (length)
        for (int i = 0; i < 33; i++) push_d($urandom_range(0, 15));  // overflow attempt
        push_d(7); do_clr();
        push_d(5); push_d(6); do_bs(); do_bs(); do_bs();  // underflow attempt
        push_d(1); push_d(2); do_set();                 // set_err
        do_clr();
        push_1234(); do_check();                        // match, fails back to 0
        for (int k = 0; k < 3; k++) begin
            push_d(9); do_check();                      // third one locks
        end
        for (int i = 0; i < LOCK_CYCLES + 5; i++) begin
            if (i % 3 == 0) do_clr();
            else push_d(i % 16);
        end
        push_1234(); do_check();                        // usable again

        for (int i = 0; i < 1000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)       push_d($urandom_range(0, 15));
            else if (r < 62)  do_bs();
            else if (r < 64)  do_check();
            else if (r < 69)  do_set();
            else if (r < 72)  do_clr();
            else if (r < 75 && m_pwset) begin
                do_clr();
                for (int j = 0; j < sto.size(); j++) push_d(sto[j]);
                do_check();
            end else
                step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
        end

        // lockout then reset in the middle of it
        idle();
        for (int k = 0; k < MAX_FAILS; k++) begin
            push_d(15); do_check();
        end
        for (int i = 0; i < 10; i++) push_d(i);
        async_reset();
        push_1234(); do_set(); push_1234(); do_check();
        repeat (3) idle();
        done = 1;
    end

endmodule
